// File: rtl/reflet_bus_arbiter.sv
// Round-robin time-slice arbiter sharing one system bus between two reflet cores.
// The non-owning core is frozen through its enable input, and every change of
// ownership passes through one dead turnaround cycle with the bus held quiet.
module reflet_bus_arbiter #(
    parameter int wordsize  = 16,
    parameter int slice_len = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_req,
    input  logic                m0_lock,
    input  logic [wordsize-1:0] m0_addr,
    input  logic [wordsize-1:0] m0_data_out,
    input  logic                m0_write_en,
    output logic                m0_enable,
    input  logic                m1_req,
    input  logic                m1_lock,
    input  logic [wordsize-1:0] m1_addr,
    input  logic [wordsize-1:0] m1_data_out,
    input  logic                m1_write_en,
    output logic                m1_enable,
    output logic [wordsize-1:0] m_data_in,
    output logic [wordsize-1:0] bus_addr,
    output logic [wordsize-1:0] bus_data_out,
    output logic                bus_write_en,
    input  logic [wordsize-1:0] bus_data_in,
    output logic [1:0]          grant
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} state_t;

    // Last counter value of a slice, compared as an 8-bit unsigned quantity.
    localparam logic [7:0] SLICE_END = 8'(slice_len - 1);

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic       next_q, next_d;

    // Owner-relative views of the request/lock inputs while in an OWN state.
    logic own_is1;
    logic req_own, req_oth, lock_own;
    logic req_next, req_other_next;

    assign own_is1        = (state_q == OWN1);
    assign req_own        = own_is1 ? m1_req  : m0_req;
    assign req_oth        = own_is1 ? m0_req  : m1_req;
    assign lock_own       = own_is1 ? m1_lock : m0_lock;
    assign req_next       = next_q  ? m1_req  : m0_req;
    assign req_other_next = next_q  ? m0_req  : m1_req;

    // Read data is broadcast to both cores without arbitration.
    assign m_data_in = bus_data_in;

    // Arbitration state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
            next_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            next_q  <= next_d;
        end
    end

    // Next-state logic: request pickup, slice accounting, release and preemption.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        next_d  = next_q;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (m0_req && m1_req) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (m0_req) begin
                    state_d = OWN0;
                end else if (m1_req) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                cnt_d = 8'(cnt_q + 8'd1);
                if (!req_own) begin
                    // Voluntary release outranks any slice-end decision.
                    last_d = own_is1;
                    cnt_d  = 8'd0;
                    if (req_oth) begin
                        state_d = TURN;
                        next_d  = ~own_is1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == SLICE_END) begin
                    cnt_d = 8'd0;
                    if (req_oth && !lock_own) begin
                        state_d = TURN;
                        next_d  = ~own_is1;
                        last_d  = own_is1;
                    end
                end
            end
            TURN: begin
                cnt_d = 8'd0;
                if (req_next) begin
                    state_d = next_q ? OWN1 : OWN0;
                end else if (req_other_next) begin
                    state_d = next_q ? OWN0 : OWN1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: the owner is passed straight through, everything else is quiet.
    always_comb begin
        m0_enable    = 1'b0;
        m1_enable    = 1'b0;
        grant        = 2'b00;
        bus_addr     = '0;
        bus_data_out = '0;
        bus_write_en = 1'b0;
        case (state_q)
            OWN0: begin
                m0_enable    = 1'b1;
                grant        = 2'b01;
                bus_addr     = m0_addr;
                bus_data_out = m0_data_out;
                bus_write_en = m0_write_en;
            end
            OWN1: begin
                m1_enable    = 1'b1;
                grant        = 2'b10;
                bus_addr     = m1_addr;
                bus_data_out = m1_data_out;
                bus_write_en = m1_write_en;
            end
            default: ;
        endcase
    end

endmodule
